audio_dac_serializer: RTL

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

---
 rtl/audio_dac_serializer.sv | 119 +++++++++++
 1 files changed

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: one-entry sample-pair holding buffer feeding a 64-slot
// frame (32-bit L then R, MSB first, one-slot delay) with BCLK divided from CLOCK_50.
module audio_dac_serializer #(
  parameter int BCLK_HALF = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [31:0] in_L,
  input  logic [31:0] in_R,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        sample_tick,
  output logic        underrun
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

  logic [7:0]  div_q,  div_d;
  logic        bclk_q, bclk_d;
  logic [5:0]  slot_q, slot_d;
  logic        full_q, full_d;
  logic [63:0] buf_q,  buf_d;
  logic [63:0] sh_q,   sh_d;
  logic [63:0] last_q, last_d;
  logic        dat_q,  dat_d;
  logic        rdy_q,  rdy_d;
  logic        tick_q, tick_d;
  logic        ur_q,   ur_d;

  logic div_wrap;
  logic bclk_fall;
  logic frame_start;
  logic accept;

  always_comb begin
    div_wrap    = (div_q == DIV_LAST);
    bclk_fall   = div_wrap && bclk_q;
    frame_start = bclk_fall && (slot_q == 6'd63);
    accept      = in_valid && rdy_q;

    div_d  = div_wrap ? 8'd0 : div_q + 8'd1;
    bclk_d = div_wrap ? !bclk_q : bclk_q;
    slot_d = slot_q;
    full_d = full_q;
    buf_d  = buf_q;
    sh_d   = sh_q;
    last_d = last_q;
    dat_d  = dat_q;
    tick_d = 1'b0;
    ur_d   = 1'b0;

    // The bit leaving the shifter is driven one slot late, so slot 0 of a
    // frame carries R[0] of the previous one.
    if (bclk_fall) begin
      slot_d = slot_q + 6'd1;
      dat_d  = sh_q[63];
      sh_d   = {sh_q[62:0], 1'b0};
    end

    if (frame_start) begin
      tick_d = 1'b1;
      if (full_q) begin
        sh_d   = buf_q;
        last_d = buf_q;
        full_d = 1'b0;
      end else begin
        sh_d = last_q;
        ur_d = 1'b1;
      end
    end

    // rdy_q is low whenever full_q is set, so an accept never collides with a load.
    if (accept) begin
      full_d = 1'b1;
      buf_d  = {in_L, in_R};
    end

    rdy_d = !full_d;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_q  <= 8'd0;
      bclk_q <= 1'b0;
      slot_q <= 6'd63;
      full_q <= 1'b0;
      buf_q  <= 64'd0;
      sh_q   <= 64'd0;
      last_q <= 64'd0;
      dat_q  <= 1'b0;
      rdy_q  <= 1'b0;
      tick_q <= 1'b0;
      ur_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      slot_q <= slot_d;
      full_q <= full_d;
      buf_q  <= buf_d;
      sh_q   <= sh_d;
      last_q <= last_d;
      dat_q  <= dat_d;
      rdy_q  <= rdy_d;
      tick_q <= tick_d;
      ur_q   <= ur_d;
    end
  end

  assign in_ready    = rdy_q;
  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = slot_q[5];
  assign AUD_DACDAT  = dat_q;
  assign sample_tick = tick_q;
  assign underrun    = ur_q;

endmodule
